move_sequencer: RTL and testbench
=================================

// Module: move_sequencer
// PURPOSE
//  Upstream controller for the move validator; also owns the authoritative 8x8 board register.
//  - Collects source/destination square selections from the cursor/UI layer.
//  - Enforces turn order and presents the candidate move to the validator.
//  - Commits the validator's next-board on success and toggles the side to move.
//  - Detects king capture and ends the game.
// PARAMETERS
//  SETTLE_CYCLES  1  cycles held in CHECK before sampling move_ok (covers validator pipeline stage); legal 1..7
//  START_WHITE    1  1: white moves first after reset; 0: black first
// PORTS
//  CLOCK_50       in   1        system clock, 50 MHz
//  reset_n        in   1        asynchronous, active-low reset
//  sel_valid      in   1        one-cycle pulse: sel_x/sel_y hold a selected square
//  sel_x, sel_y   in   3 each   selected column / row
//  cancel         in   1        one-cycle pulse: abort a move in progress
//  move_ok        in   1        validator verdict for the presented move
//  board_next     in   4 [8][8] validator's post-move board
//  old_x, old_y   out  3 each   source square presented to validator
//  new_x, new_y   out  3 each   destination square presented to validator
//  piece_type     out  4        code of the piece on the source square
//  board          out  4 [8][8] committed board, indexed [y][x]
//  white_turn     out  1        1 = white to move
//  busy           out  1        high in CHECK
//  move_done      out  1        one-cycle pulse on commit
//  move_rejected  out  1        one-cycle pulse on validator reject or illegal source selection
//  game_over      out  1        high after a king is captured
// BEHAVIOUR
//  Piece codes:
//   - White 0..5 = R N B Q K P; black 6..11 = R N B Q K P; 15 = empty.
//   - Codes 12..14 are treated as empty.
//  Reset (async):
//   - State = SRC; white_turn = START_WHITE.
//   - All position outputs and piece_type = 0; all pulses, busy and game_over = 0.
//   - board: row 0 = 0,1,2,3,4,2,1,0; row 1 = 5 x8; rows 2..5 = 15; row 6 = 11 x8; row 7 = 6,7,8,9,10,8,7,6.
//   - A reset asserted mid-move aborts the move with no commit.
//  FSM: SRC -> DST -> CHECK -> SRC, plus terminal OVER. All transitions on the CLOCK_50 edge.
//  Own piece: code 0..5 when white_turn = 1, or code 6..11 when white_turn = 0.
//  SRC (waiting for a source square):
//   - On sel_valid with board[sel_y][sel_x] = own piece: latch old_x/old_y and piece_type, then go to DST.
//   - On sel_valid with an empty or enemy square: pulse move_rejected and stay in SRC.
//  DST (source held, waiting for a destination), on sel_valid:
//   - Same square as the source: deselect and go to SRC, no pulse.
//   - Another own piece: re-latch it as the source and stay in DST.
//   - Otherwise: latch new_x/new_y and go to CHECK.
//  cancel:
//   - In DST or CHECK: go to SRC, no pulse, board unchanged.
//   - cancel wins over a simultaneous sel_valid.
//  CHECK:
//   - busy = 1 and all position outputs are held stable; sel_valid is ignored.
//   - A counter runs for SETTLE_CYCLES; move_ok is sampled on the following cycle.
//   - move_ok = 1: board <= board_next, toggle white_turn, pulse move_done, go to SRC.
//     If the pre-commit board[new_y][new_x] is 4 or 10, go to OVER instead and set game_over.
//   - move_ok = 0: pulse move_rejected, board and turn unchanged, go to SRC.
//  Latency: destination sel_valid at edge N gives commit/reject at edge N+SETTLE_CYCLES+1.
//  Pulses are exactly one cycle wide; move_done and move_rejected are never high together.
//  OVER: ignores sel_valid and cancel; holds board; game_over stays 1 until reset.
//  Position outputs keep their last latched values while in SRC.
// TESTING
//  1. Reset; sel (4,1) then (4,3) with move_ok = 1 -> move_done at edge N+2; board[3][4] = 5;
//     board[1][4] = 15; white_turn = 0.
//  2. White to move; sel (0,6) -> move_rejected pulse, state stays SRC, old_x/old_y unchanged.
//  3. sel (1,0), sel (2,0) (own piece) -> source re-latched: old_x = 2, piece_type = 2; still in DST.
//  4. sel (6,0), sel (5,2), move_ok = 0 -> move_rejected one cycle; board identical; white_turn = 1.
//  5. In CHECK, assert cancel together with sel_valid -> SRC, no move_done, board unchanged;
//     assert reset_n low mid-CHECK -> initial board.
//  6. Preload a position with a white queen next to the black king; commit the capture ->
//     move_done, game_over = 1; later sel_valid pulses have no effect.

Source files
------------

// File: rtl/move_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : move_sequencer_if
// Purpose  : Selection, validator and board signals of the move sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface move_sequencer_if;
    typedef logic [7:0][7:0][3:0] board_t;

    logic       sel_valid;
    logic [2:0] sel_x;
    logic [2:0] sel_y;
    logic       cancel;
    logic       move_ok;
    board_t     board_next;

    logic [2:0] old_x;
    logic [2:0] old_y;
    logic [2:0] new_x;
    logic [2:0] new_y;
    logic [3:0] piece_type;
    board_t     board;
    logic       white_turn;
    logic       busy;
    logic       move_done;
    logic       move_rejected;
    logic       game_over;

    modport master (
        output sel_valid, sel_x, sel_y, cancel, move_ok, board_next,
        input  old_x, old_y, new_x, new_y, piece_type, board,
        input  white_turn, busy, move_done, move_rejected, game_over
    );

    modport slave (
        input  sel_valid, sel_x, sel_y, cancel, move_ok, board_next,
        output old_x, old_y, new_x, new_y, piece_type, board,
        output white_turn, busy, move_done, move_rejected, game_over
    );
endinterface
`default_nettype wire

// File: rtl/move_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : move_sequencer
// Purpose  : Turn-ordered move collection, validator hand-off and board commit.
// Revision : 1.0 - initial release
// ============================================================================
module move_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter bit START_WHITE   = 1'b1
) (
    input wire            CLOCK_50,
    input wire            reset_n,
    move_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_SRC   = 2'd0,
        S_DST   = 2'd1,
        S_CHECK = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    // Rows listed y=7 down to y=0; within a row x=7 down to x=0.
    localparam logic [7:0][7:0][3:0] c_INIT_BOARD = {
        {4'd6, 4'd7, 4'd8, 4'd10, 4'd9, 4'd8, 4'd7, 4'd6},
        {8{4'd11}},
        {8{4'hF}}, {8{4'hF}}, {8{4'hF}}, {8{4'hF}},
        {8{4'd5}},
        {4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0}
    };

    state_t                r_state;
    state_t                w_state_next;
    logic [2:0]            r_cnt;
    logic [7:0][7:0][3:0]  r_board;
    logic                  r_white_turn;
    logic [2:0]            r_old_x, r_old_y, r_new_x, r_new_y;
    logic [3:0]            r_piece_type;
    logic                  r_move_done, r_move_rejected, r_game_over;

    logic [3:0] w_sel_piece;
    logic [3:0] w_dst_piece;
    logic       w_sel_own, w_same_sq, w_settled, w_king_hit;
    logic       w_latch_src, w_latch_dst, w_commit, w_reject;

    assign w_sel_piece = r_board[bus.sel_y][bus.sel_x];
    assign w_dst_piece = r_board[r_new_y][r_new_x];
    assign w_sel_own   = r_white_turn ? (w_sel_piece <= 4'd5)
                                      : (w_sel_piece >= 4'd6 && w_sel_piece <= 4'd11);
    assign w_same_sq   = (bus.sel_x == r_old_x) && (bus.sel_y == r_old_y);
    assign w_settled   = (r_cnt == 3'(SETTLE_CYCLES));
    assign w_king_hit  = (w_dst_piece == 4'd4) || (w_dst_piece == 4'd10);

    always_comb begin
        w_state_next = r_state;
        w_latch_src  = 1'b0;
        w_latch_dst  = 1'b0;
        w_commit     = 1'b0;
        w_reject     = 1'b0;
        case (r_state)
            S_SRC: begin
                if (bus.sel_valid) begin
                    if (w_sel_own) begin
                        w_latch_src  = 1'b1;
                        w_state_next = S_DST;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            S_DST: begin
                if (bus.cancel) begin
                    w_state_next = S_SRC;
                end else if (bus.sel_valid) begin
                    if (w_same_sq) begin
                        w_state_next = S_SRC;
                    end else if (w_sel_own) begin
                        w_latch_src = 1'b1;
                    end else begin
                        w_latch_dst  = 1'b1;
                        w_state_next = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                // move_ok is only trusted once the validator pipeline has settled.
                if (bus.cancel) begin
                    w_state_next = S_SRC;
                end else if (w_settled) begin
                    if (bus.move_ok) begin
                        w_commit     = 1'b1;
                        w_state_next = w_king_hit ? S_OVER : S_SRC;
                    end else begin
                        w_reject     = 1'b1;
                        w_state_next = S_SRC;
                    end
                end
            end
            S_OVER:  w_state_next = S_OVER;
            default: w_state_next = S_SRC;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_SRC;
            r_cnt           <= 3'd0;
            r_board         <= c_INIT_BOARD;
            r_white_turn    <= START_WHITE;
            r_old_x         <= 3'd0;
            r_old_y         <= 3'd0;
            r_new_x         <= 3'd0;
            r_new_y         <= 3'd0;
            r_piece_type    <= 4'd0;
            r_move_done     <= 1'b0;
            r_move_rejected <= 1'b0;
            r_game_over     <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_cnt           <= (r_state == S_CHECK) ? r_cnt + 3'd1 : 3'd0;
            r_move_done     <= w_commit;
            r_move_rejected <= w_reject;
            if (w_latch_src) begin
                r_old_x      <= bus.sel_x;
                r_old_y      <= bus.sel_y;
                r_piece_type <= w_sel_piece;
            end
            if (w_latch_dst) begin
                r_new_x <= bus.sel_x;
                r_new_y <= bus.sel_y;
            end
            if (w_commit) begin
                r_board      <= bus.board_next;
                r_white_turn <= ~r_white_turn;
                if (w_king_hit) begin
                    r_game_over <= 1'b1;
                end
            end
        end
    end

    assign bus.old_x         = r_old_x;
    assign bus.old_y         = r_old_y;
    assign bus.new_x         = r_new_x;
    assign bus.new_y         = r_new_y;
    assign bus.piece_type    = r_piece_type;
    assign bus.board         = r_board;
    assign bus.white_turn    = r_white_turn;
    assign bus.busy          = (r_state == S_CHECK);
    assign bus.move_done     = r_move_done;
    assign bus.move_rejected = r_move_rejected;
    assign bus.game_over     = r_game_over;
endmodule
`default_nettype wire

// File: tb/tb_move_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_move_sequencer
// Purpose  : Directed vectors, corner sequences and random play vs. a move model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_move_sequencer;
    localparam int SETTLE = 1;
    typedef logic [7:0][7:0][3:0] board_t;

    logic CLOCK_50 = 1'b0;
    logic reset_n  = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    move_sequencer_if bus();

    move_sequencer #(.SETTLE_CYCLES(SETTLE), .START_WHITE(1'b1)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the game as a board of codes plus the move in progress.
    int mb[8][8];
    bit m_white, m_over, m_hold, m_pend, m_done, m_rej;
    int m_sx, m_sy, m_dx, m_dy, m_piece, m_left;

    bit     ovr_en = 1'b0;
    board_t ovr_bd;

    function automatic bit is_own(input int code, input bit white);
        return white ? (code >= 0 && code <= 5) : (code >= 6 && code <= 11);
    endfunction

    task automatic model_reset();
        int back[8] = '{0, 1, 2, 3, 4, 2, 1, 0};
        for (int x = 0; x < 8; x++) begin
            mb[0][x] = back[x];
            mb[1][x] = 5;
            for (int y = 2; y < 6; y++) mb[y][x] = 15;
            mb[6][x] = 11;
            mb[7][x] = back[x] + 6;
        end
        m_white = 1'b1; m_over = 0; m_hold = 0; m_pend = 0; m_done = 0; m_rej = 0;
        m_sx = 0; m_sy = 0; m_dx = 0; m_dy = 0; m_piece = 0; m_left = 0;
    endtask

    function automatic board_t pack_model();
        board_t b;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) b[y][x] = 4'(mb[y][x]);
        return b;
    endfunction

    // Validator stand-in: the post-move board simply relocates the source piece.
    function automatic board_t standin();
        board_t b = pack_model();
        if (m_pend) begin
            b[m_dy][m_dx] = 4'(mb[m_sy][m_sx]);
            b[m_sy][m_sx] = 4'hF;
        end
        return b;
    endfunction

    task automatic model_step(input bit sv, input int x, input int y, input bit cn,
                              input bit ok, input board_t bn);
        m_done = 0; m_rej = 0;
        if (m_over) return;
        if (m_pend) begin
            if (cn) m_pend = 0;
            else if (m_left > 0) m_left--;
            else begin
                m_pend = 0;
                if (ok) begin
                    bit cap = (mb[m_dy][m_dx] == 4) || (mb[m_dy][m_dx] == 10);
                    for (int r = 0; r < 8; r++)
                        for (int c = 0; c < 8; c++) mb[r][c] = int'(bn[r][c]);
                    m_white = !m_white;
                    m_done  = 1;
                    if (cap) m_over = 1;
                end else m_rej = 1;
            end
        end else if (m_hold) begin
            if (cn) m_hold = 0;
            else if (sv) begin
                if (x == m_sx && y == m_sy) m_hold = 0;
                else if (is_own(mb[y][x], m_white)) begin
                    m_sx = x; m_sy = y; m_piece = mb[y][x];
                end else begin
                    m_dx = x; m_dy = y; m_hold = 0; m_pend = 1; m_left = SETTLE;
                end
            end
        end else if (sv) begin
            if (is_own(mb[y][x], m_white)) begin
                m_sx = x; m_sy = y; m_piece = mb[y][x]; m_hold = 1;
            end else m_rej = 1;
        end
    endtask

    task automatic check_all(input string tag);
        bit bad;
        checks++;
        bad = (bus.board !== pack_model()) || (bus.old_x !== 3'(m_sx)) || (bus.old_y !== 3'(m_sy))
            || (bus.new_x !== 3'(m_dx)) || (bus.new_y !== 3'(m_dy)) || (bus.piece_type !== 4'(m_piece))
            || (bus.white_turn !== m_white) || (bus.busy !== m_pend) || (bus.move_done !== m_done)
            || (bus.move_rejected !== m_rej) || (bus.game_over !== m_over);
        if (bad) begin
            errors++;
            $display("FAIL %s: got old=(%0d,%0d) new=(%0d,%0d) pt=%0d wt=%0b busy=%0b done=%0b rej=%0b go=%0b brd_ok=%0b; want old=(%0d,%0d) new=(%0d,%0d) pt=%0d wt=%0b busy=%0b done=%0b rej=%0b go=%0b",
                     tag, bus.old_x, bus.old_y, bus.new_x, bus.new_y, bus.piece_type, bus.white_turn,
                     bus.busy, bus.move_done, bus.move_rejected, bus.game_over, bus.board === pack_model(),
                     m_sx, m_sy, m_dx, m_dy, m_piece, m_white, m_pend, m_done, m_rej, m_over);
        end
    endtask

    task automatic expect_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic cycle(input bit sv, input int x, input int y, input bit cn, input bit ok);
        board_t bn = ovr_en ? ovr_bd : standin();
        bus.sel_valid  = sv;
        bus.sel_x      = 3'(x);
        bus.sel_y      = 3'(y);
        bus.cancel     = cn;
        bus.move_ok    = ok;
        bus.board_next = bn;
        model_step(sv, x, y, cn, ok, bn);
        @(posedge CLOCK_50);
        #1;
        check_all("scoreboard");
    endtask

    task automatic async_reset(input string tag);
        bus.sel_valid = 1'b0;
        bus.cancel    = 1'b0;
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_all(tag);
        @(negedge CLOCK_50);
        reset_n = 1'b1;
    endtask

    typedef struct {
        int sv, x, y, cn, ok;
        int eox, eoy, ept, ewt, ebusy, edone, erej;
    } vec_t;
    vec_t tbl[23];

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{1,4,1,0,0, 4,1,5,1,0,0,0};
        tbl[1]  = '{1,4,3,0,0, 4,1,5,1,1,0,0};
        tbl[2]  = '{0,0,0,0,1, 4,1,5,1,1,0,0};
        tbl[3]  = '{0,0,0,0,1, 4,1,5,0,0,1,0};
        tbl[4]  = '{1,0,6,0,0, 0,6,11,0,0,0,0};
        tbl[5]  = '{1,0,5,0,0, 0,6,11,0,1,0,0};
        tbl[6]  = '{0,0,0,0,1, 0,6,11,0,1,0,0};
        tbl[7]  = '{0,0,0,0,1, 0,6,11,1,0,1,0};
        tbl[8]  = '{1,1,6,0,0, 0,6,11,1,0,0,1};
        tbl[9]  = '{1,4,4,0,0, 0,6,11,1,0,0,1};
        tbl[10] = '{1,1,0,0,0, 1,0,1,1,0,0,0};
        tbl[11] = '{1,2,0,0,0, 2,0,2,1,0,0,0};
        tbl[12] = '{1,2,0,0,0, 2,0,2,1,0,0,0};
        tbl[13] = '{1,6,0,0,0, 6,0,1,1,0,0,0};
        tbl[14] = '{1,5,2,0,0, 6,0,1,1,1,0,0};
        tbl[15] = '{0,0,0,0,0, 6,0,1,1,1,0,0};
        tbl[16] = '{0,0,0,0,0, 6,0,1,1,0,0,1};
        tbl[17] = '{0,0,0,0,0, 6,0,1,1,0,0,0};
        tbl[18] = '{1,6,0,0,0, 6,0,1,1,0,0,0};
        tbl[19] = '{1,5,2,0,0, 6,0,1,1,1,0,0};
        tbl[20] = '{1,7,7,1,1, 6,0,1,1,0,0,0};
        tbl[21] = '{0,0,0,0,1, 6,0,1,1,0,0,0};
        tbl[22] = '{1,5,2,0,0, 6,0,1,1,0,0,1};

        bus.sel_valid = 0; bus.sel_x = 0; bus.sel_y = 0;
        bus.cancel = 0; bus.move_ok = 0; bus.board_next = '0;
        model_reset();
        repeat (2) @(posedge CLOCK_50);
        #1 check_all("reset_state");
        expect_int("reset_white_king", int'(bus.board[0][4]), 4);
        expect_int("reset_black_king", int'(bus.board[7][4]), 10);
        @(negedge CLOCK_50);
        reset_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            cycle(tbl[i].sv[0], tbl[i].x, tbl[i].y, tbl[i].cn[0], tbl[i].ok[0]);
            checks++;
            if (bus.old_x !== 3'(tbl[i].eox) || bus.old_y !== 3'(tbl[i].eoy)
                || bus.piece_type !== 4'(tbl[i].ept) || bus.white_turn !== tbl[i].ewt[0]
                || bus.busy !== tbl[i].ebusy[0] || bus.move_done !== tbl[i].edone[0]
                || bus.move_rejected !== tbl[i].erej[0]) begin
                errors++;
                $display("FAIL vec%0d: got old=(%0d,%0d) pt=%0d wt=%0b busy=%0b done=%0b rej=%0b; want old=(%0d,%0d) pt=%0d wt=%0d busy=%0d done=%0d rej=%0d",
                         i, bus.old_x, bus.old_y, bus.piece_type, bus.white_turn, bus.busy,
                         bus.move_done, bus.move_rejected, tbl[i].eox, tbl[i].eoy, tbl[i].ept,
                         tbl[i].ewt, tbl[i].ebusy, tbl[i].edone, tbl[i].erej);
            end
        end
        expect_int("pawn_landed_4_3", int'(bus.board[3][4]), 5);
        expect_int("pawn_left_4_1", int'(bus.board[1][4]), 15);
        expect_int("black_pawn_0_5", int'(bus.board[5][0]), 11);
        expect_int("knight_stays_6_0", int'(bus.board[0][6]), 1);

        // Reset arriving while a move is being validated.
        cycle(1, 3, 1, 0, 0);
        cycle(1, 3, 2, 0, 1);
        expect_int("busy_before_reset", int'(bus.busy), 1);
        async_reset("reset_mid_check");
        expect_int("reset_restores_4_1", int'(bus.board[1][4]), 5);
        expect_int("reset_restores_4_3", int'(bus.board[3][4]), 15);
        cycle(0, 0, 0, 0, 1);

        // King capture from a preloaded position.
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) ovr_bd[r][c] = 4'hF;
        ovr_bd[0][4] = 4'd4;  ovr_bd[5][3] = 4'd3;
        ovr_bd[5][4] = 4'd10; ovr_bd[6][0] = 4'd11;
        ovr_en = 1'b1;
        cycle(1, 3, 1, 0, 0); cycle(1, 3, 3, 0, 1); cycle(0, 0, 0, 0, 1); cycle(0, 0, 0, 0, 1);
        ovr_en = 1'b0;
        expect_int("preload_black_king", int'(bus.board[5][4]), 10);
        cycle(1, 0, 6, 0, 0); cycle(1, 0, 5, 0, 1); cycle(0, 0, 0, 0, 1); cycle(0, 0, 0, 0, 1);
        cycle(1, 3, 5, 0, 0); cycle(1, 4, 5, 0, 1); cycle(0, 0, 0, 0, 1); cycle(0, 0, 0, 0, 1);
        expect_int("capture_move_done", int'(bus.move_done), 1);
        expect_int("capture_game_over", int'(bus.game_over), 1);
        cycle(1, 0, 5, 0, 1); cycle(1, 4, 0, 1, 1); cycle(1, 3, 3, 0, 1);
        expect_int("over_queen_on_4_5", int'(bus.board[5][4]), 3);
        expect_int("over_no_reject", int'(bus.move_rejected), 0);
        expect_int("over_sticky", int'(bus.game_over), 1);
        expect_int("over_old_x_held", int'(bus.old_x), 3);

        // Random play against the model.
        async_reset("reset_before_random");
        for (int i = 0; i < 3000; i++) begin
            int sx, sy, q[$];
            bit sv, cn, ok;
            if ((m_over && $urandom_range(0, 3) == 0) || $urandom_range(0, 499) == 0) begin
                async_reset("random_reset");
                continue;
            end
            sv = 1'($urandom_range(0, 1));
            cn = ($urandom_range(0, 19) == 0);
            ok = ($urandom_range(0, 9) < 7);
            sx = $urandom_range(0, 7);
            sy = $urandom_range(0, 7);
            if ($urandom_range(0, 9) < 5) begin
                for (int p = 0; p < 64; p++) if (is_own(mb[p / 8][p % 8], m_white)) q.push_back(p);
                if (q.size() > 0) begin
                    int pick = q[$urandom_range(0, q.size() - 1)];
                    sx = pick % 8;
                    sy = pick / 8;
                end
            end
            cycle(sv, sx, sy, cn, ok);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
